// File: rtl/fold_pkg.sv
// Shared types and sizing helpers for the fold sequencer and its slot picker.
package fold_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Select width never collapses to zero, even for a one-slot request vector.
  function automatic int sel_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fold_picker.sv
// Combinational picker: hands the FOLDS highest set bits of the pending mask
// to the lanes in descending order and reports which bits were taken.
module fold_picker
  import fold_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FOLDS = 2,
  parameter int SEL_W = sel_w(WIDTH)
) (
  input  logic [WIDTH-1:0]            pending_i,
  output logic [FOLDS-1:0][SEL_W-1:0] sel_o,
  output logic [FOLDS-1:0]            none_o,
  output logic [WIDTH-1:0]            granted_o
);

  logic [WIDTH-1:0] rem;
  int               hi;

  always_comb begin
    rem       = pending_i;
    sel_o     = '0;
    none_o    = '1;
    granted_o = '0;
    hi        = -1;
    for (int f = 0; f < FOLDS; f++) begin
      hi = -1;
      // Ascending scan: the last hit is the highest remaining bit.
      for (int b = 0; b < WIDTH; b++) begin
        if (rem[b]) hi = b;
      end
      if (hi >= 0) begin
        sel_o[f]  = SEL_W'(hi);
        none_o[f] = 1'b0;
        rem[hi]   = 1'b0;
      end
    end
    granted_o = pending_i & ~rem;
  end

endmodule

// File: rtl/fold_sequencer.sv
// Start/hold/done sequencer that drains a latched slot mask onto FOLDS lanes
// per beat, highest slot first, with an almost-done flag on the final beat.
module fold_sequencer
  import fold_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int FOLDS = 2,
  localparam int SEL_W = sel_w(WIDTH)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [WIDTH-1:0]            i_request,
  input  logic                        i_hold,
  output logic                        o_busy,
  output logic [FOLDS-1:0][SEL_W-1:0] o_mux_sel,
  output logic [FOLDS-1:0]            o_mux_none,
  output logic                        o_adone,
  output logic                        o_done
);

  state_e                      state_q;
  logic [WIDTH-1:0]            pending_q;
  logic [FOLDS-1:0][SEL_W-1:0] pick_sel;
  logic [FOLDS-1:0]            pick_none;
  logic [WIDTH-1:0]            pick_granted;
  logic [WIDTH-1:0]            pending_d;
  logic                        beat;

  fold_picker #(
    .WIDTH (WIDTH),
    .FOLDS (FOLDS),
    .SEL_W (SEL_W)
  ) u_picker (
    .pending_i (pending_q),
    .sel_o     (pick_sel),
    .none_o    (pick_none),
    .granted_o (pick_granted)
  );

  // RUN is only ever entered with a non-empty mask, so every unheld RUN cycle is a beat.
  assign beat      = (state_q == RUN) && !i_hold;
  assign pending_d = pending_q & ~pick_granted;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            pending_q <= i_request;
            state_q   <= (i_request != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (!i_hold) begin
            pending_q <= pending_d;
            if (pending_d == '0) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < FOLDS; gi++) begin : g_lane
      assign o_mux_sel[gi]  = beat ? pick_sel[gi] : '0;
      assign o_mux_none[gi] = beat ? pick_none[gi] : 1'b1;
    end
  endgenerate

  assign o_adone = beat && (pending_d == '0);
  assign o_busy  = (state_q != IDLE);
  assign o_done  = (state_q == DONE);

endmodule

// File: tb/tb_fold_sequencer.sv
// Directed, table-driven bench for fold_sequencer (WIDTH=8, FOLDS=2): one row per cycle.
module tb_fold_sequencer;

  localparam int WIDTH = 8;
  localparam int FOLDS = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [WIDTH-1:0]      req;
  logic                  hold;
  logic                  busy;
  logic [FOLDS-1:0][2:0] sel;
  logic [FOLDS-1:0]      none;
  logic                  adone;
  logic                  done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fold_sequencer #(.WIDTH(WIDTH), .FOLDS(FOLDS)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_request  (req),
    .i_hold     (hold),
    .o_busy     (busy),
    .o_mux_sel  (sel),
    .o_mux_none (none),
    .o_adone    (adone),
    .o_done     (done)
  );

  typedef struct {
    logic       start;
    logic [7:0] req;
    logic       hold;
    logic       rst;
    logic       busy;
    logic [1:0] none;
    logic [2:0] s0;
    logic [2:0] s1;
    logic       adone;
    logic       done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic st, input logic [7:0] rq, input logic hd,
                             input logic rs, input logic bz, input logic [1:0] nn,
                             input logic [2:0] a, input logic [2:0] b,
                             input logic ad, input logic dn);
    vec_t r;
    r.start = st; r.req = rq; r.hold = hd; r.rst = rs;
    r.busy = bz; r.none = nn; r.s0 = a; r.s1 = b; r.adone = ad; r.done = dn;
    return r;
  endfunction

  task automatic chk(input string name, input int row, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int beats;
  int exp_idx;
  bit seen_adone;

  initial begin
    rst = 1'b1; start = 1'b0; req = '0; hold = 1'b0;
    step(); step();
    rst = 1'b0;

    // Columns: start req hold rst | busy none s0 s1 adone done
    // Reset state
    tbl.push_back(v(0, 8'h00, 0, 0, 0, 2'b11, 0, 0, 0, 0));
    // T1: C5, request changes mid-packet ignored
    tbl.push_back(v(1, 8'hC5, 0, 0, 0, 2'b11, 0, 0, 0, 0));
    tbl.push_back(v(0, 8'hFF, 0, 0, 1, 2'b00, 7, 6, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b00, 2, 0, 1, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b11, 0, 0, 0, 1));
    tbl.push_back(v(0, 8'h00, 0, 0, 0, 2'b11, 0, 0, 0, 0));
    // T2: single bit, lane 1 idle
    tbl.push_back(v(1, 8'h20, 0, 0, 0, 2'b11, 0, 0, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b10, 5, 0, 1, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b11, 0, 0, 0, 1));
    tbl.push_back(v(0, 8'h00, 0, 0, 0, 2'b11, 0, 0, 0, 0));
    // T3: empty request, hold in IDLE and DONE has no effect
    tbl.push_back(v(1, 8'h00, 1, 0, 0, 2'b11, 0, 0, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 1, 2'b11, 0, 0, 0, 1));
    tbl.push_back(v(0, 8'h00, 0, 0, 0, 2'b11, 0, 0, 0, 0));
    // T4: full mask with one hold cycle
    tbl.push_back(v(1, 8'hFF, 0, 0, 0, 2'b11, 0, 0, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 1, 2'b11, 0, 0, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b00, 7, 6, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b00, 5, 4, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b00, 3, 2, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b00, 1, 0, 1, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b11, 0, 0, 0, 1));
    tbl.push_back(v(0, 8'h00, 0, 0, 0, 2'b11, 0, 0, 0, 0));
    // T5: re-start while busy ignored, start after done accepted
    tbl.push_back(v(1, 8'hF0, 0, 0, 0, 2'b11, 0, 0, 0, 0));
    tbl.push_back(v(1, 8'h0F, 0, 0, 1, 2'b00, 7, 6, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b00, 5, 4, 1, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b11, 0, 0, 0, 1));
    tbl.push_back(v(1, 8'h0F, 0, 0, 0, 2'b11, 0, 0, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b00, 3, 2, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b00, 1, 0, 1, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b11, 0, 0, 0, 1));
    tbl.push_back(v(0, 8'h00, 0, 0, 0, 2'b11, 0, 0, 0, 0));
    // T6: reset mid-packet, no done pulse, then a clean full-mask run
    tbl.push_back(v(1, 8'hFF, 0, 0, 0, 2'b11, 0, 0, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b00, 7, 6, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 1, 1, 2'b00, 5, 4, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 0, 2'b11, 0, 0, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 0, 2'b11, 0, 0, 0, 0));
    tbl.push_back(v(1, 8'hFF, 0, 0, 0, 2'b11, 0, 0, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b00, 7, 6, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b00, 5, 4, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b00, 3, 2, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b00, 1, 0, 1, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b11, 0, 0, 0, 1));
    tbl.push_back(v(0, 8'h00, 0, 0, 0, 2'b11, 0, 0, 0, 0));
    // T7: start together with reset, reset wins
    tbl.push_back(v(1, 8'h81, 0, 1, 0, 2'b11, 0, 0, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 0, 2'b11, 0, 0, 0, 0));
    // T8: multi-cycle hold freezes the pending mask
    tbl.push_back(v(1, 8'h0A, 0, 0, 0, 2'b11, 0, 0, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 1, 2'b11, 0, 0, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 1, 2'b11, 0, 0, 0, 0));
    tbl.push_back(v(0, 8'h00, 0, 0, 1, 2'b00, 3, 1, 1, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 1, 2'b11, 0, 0, 0, 1));
    tbl.push_back(v(0, 8'h00, 0, 0, 0, 2'b11, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start; req = tbl[i].req; hold = tbl[i].hold; rst = tbl[i].rst;
      #1;
      $display("row %0d: start=%0b req=%h hold=%0b rst=%0b -> busy=%0b none=%b sel=%0d,%0d adone=%0b done=%0b",
               i, start, req, hold, rst, busy, none, sel[0], sel[1], adone, done);
      chk("busy",  i, {7'd0, busy},  {7'd0, tbl[i].busy});
      chk("none",  i, {6'd0, none},  {6'd0, tbl[i].none});
      chk("sel0",  i, {5'd0, sel[0]}, {5'd0, tbl[i].s0});
      chk("sel1",  i, {5'd0, sel[1]}, {5'd0, tbl[i].s1});
      chk("adone", i, {7'd0, adone}, {7'd0, tbl[i].adone});
      chk("done",  i, {7'd0, done},  {7'd0, tbl[i].done});
      step();
    end
    start = 1'b0; req = '0; hold = 1'b0; rst = 1'b0;

    // Bounded drain of a full mask: every slot exactly once, strictly descending.
    start = 1'b1; req = 8'hFF;
    step();
    start = 1'b0; req = '0;
    beats = 0; exp_idx = 7; seen_adone = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen_adone; cyc++) begin
      #1;
      for (int l = 0; l < FOLDS; l++) begin
        if (!none[l]) begin
          chk("order", 100 + cyc, {5'd0, sel[l]}, 8'(exp_idx));
          exp_idx--;
        end
      end
      if (none != 2'b11) beats++;
      if (adone) seen_adone = 1'b1;
      $display("drain cycle %0d: none=%b sel=%0d,%0d adone=%0b", cyc, none, sel[0], sel[1], adone);
      step();
    end
    chk("drain_adone", 200, {7'd0, seen_adone}, 8'd1);
    chk("drain_beats", 201, 8'(beats), 8'd4);
    chk("drain_slots", 202, 8'(exp_idx + 1), 8'd0);
    #1;
    chk("drain_done", 203, {7'd0, done}, 8'd1);
    step();
    #1;
    chk("drain_idle", 204, {7'd0, busy}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
